// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC, next-PC select and IF/ID pipeline latch
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   pc_en, id_en, flushed     hazard-unit controls: PC update, IF/ID load, IF/ID squash
//   pc_src                    next-PC select: 0=PC+step, 1=branch, 2=jump, 3=jr
//   branch_addr, jump_addr    redirect targets (jump_addr is the J-type 26-bit field)
//   jr_addr                   register target for jr
//   halt                      stop fetching; leaves HALTED only through reset
//   ihit, imemload            instruction memory hit and returned word
//   imemREN, imemaddr         instruction memory read request and address (= pc)
//   instr_id, npc_id          IF/ID instruction and its PC+step
//   valid_id                  IF/ID holds a real instruction
//   fetch_cnt                 number of instructions loaded into IF/ID
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        id_en,
    input  logic        flushed,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_addr,
    input  logic [25:0] jump_addr,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_id,
    output logic [31:0] npc_id,
    output logic        valid_id,
    output logic [31:0] fetch_cnt
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] target;
    logic        run;
    assign run      = (state == RUN);
    assign pc_seq   = pc + PC_STEP;
    assign imemREN  = run;
    assign imemaddr = pc;
    // jump keeps the upper nibble of the delay-slot PC held in IF/ID
    always_comb
        target = pc_src == 2'd1 ? branch_addr :
                 pc_src == 2'd2 ? {npc_id[31:28], jump_addr, 2'b00} :
                 pc_src == 2'd3 ? jr_addr : pc_seq;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            pc        <= PC_INIT;
            instr_id  <= '0;
            npc_id    <= '0;
            valid_id  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (run) begin
                if (halt)
                    state <= HALTED;
                // a redirect wins over an outstanding fetch
                if (pc_en && pc_src != 2'd0)
                    pc <= target;
                else if (pc_en && ihit)
                    pc <= pc_seq;
            end
            if (flushed) begin
                instr_id <= '0;
                npc_id   <= '0;
                valid_id <= 1'b0;
            end else if (id_en) begin
                if (run && ihit) begin
                    instr_id  <= imemload;
                    npc_id    <= pc_seq;
                    valid_id  <= 1'b1;
                    fetch_cnt <= fetch_cnt + 32'd1;
                end else begin
                    instr_id <= '0;
                    npc_id   <= '0;
                    valid_id <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed test of fetch_stage
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pc_en = 1'b0, id_en = 1'b0, flushed = 1'b0, halt = 1'b0, ihit = 1'b0;
    logic [1:0]  pc_src = 2'd0;
    logic [31:0] branch_addr = '0, jr_addr = '0, imemload = '0;
    logic [25:0] jump_addr = '0;
    logic        imemREN, valid_id;
    logic [31:0] imemaddr, instr_id, npc_id, fetch_cnt;
    int total = 0;
    int bad = 0;

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .id_en(id_en), .flushed(flushed),
        .pc_src(pc_src), .branch_addr(branch_addr), .jump_addr(jump_addr), .jr_addr(jr_addr),
        .halt(halt), .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
        .instr_id(instr_id), .npc_id(npc_id), .valid_id(valid_id), .fetch_cnt(fetch_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pe, ie, fl;
        logic [1:0]  src;
        logic [31:0] br;
        logic [25:0] jmp;
        logic [31:0] jr;
        logic        hlt, hit;
        logic [31:0] ld;
        logic [31:0] e_addr;
        logic        e_ren;
        logic [31:0] e_ins, e_npc;
        logic        e_vld;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic pe, logic ie, logic fl, logic [1:0] src, logic [31:0] br,
                                logic [25:0] jmp, logic [31:0] jr, logic hlt, logic hit,
                                logic [31:0] ld, logic [31:0] e_addr, logic e_ren,
                                logic [31:0] e_ins, logic [31:0] e_npc, logic e_vld,
                                logic [31:0] e_cnt);
        vec_t r;
        r.pe = pe; r.ie = ie; r.fl = fl; r.src = src; r.br = br; r.jmp = jmp; r.jr = jr;
        r.hlt = hlt; r.hit = hit; r.ld = ld; r.e_addr = e_addr; r.e_ren = e_ren;
        r.e_ins = e_ins; r.e_npc = e_npc; r.e_vld = e_vld; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(int idx, logic [31:0] a, logic r, logic [31:0] i, logic [31:0] n,
                           logic vl, logic [31:0] c);
        chk("imemaddr", idx, imemaddr, a);
        chk("imemREN", idx, {31'd0, imemREN}, {31'd0, r});
        chk("instr_id", idx, instr_id, i);
        chk("npc_id", idx, npc_id, n);
        chk("valid_id", idx, {31'd0, valid_id}, {31'd0, vl});
        chk("fetch_cnt", idx, fetch_cnt, c);
    endtask

    task automatic drive(vec_t x);
        pc_en = x.pe; id_en = x.ie; flushed = x.fl; pc_src = x.src; branch_addr = x.br;
        jump_addr = x.jmp; jr_addr = x.jr; halt = x.hlt; ihit = x.hit; imemload = x.ld;
    endtask

    initial begin
        //        pe ie fl src br            jmp     jr          h  hit ld           addr          ren ins          npc           vld cnt
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hA0,      32'h4,        1, 32'hA0,      32'h4,        1, 1));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hA1,      32'h8,        1, 32'hA1,      32'h8,        1, 2));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hA2,      32'hC,        1, 32'hA2,      32'hC,        1, 3));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hA3,      32'h10,       1, 32'hA3,      32'h10,       1, 4));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 0, 32'hEE,      32'h10,       1, 0,           0,            0, 4));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 0, 32'hEE,      32'h10,       1, 0,           0,            0, 4));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hB0,      32'h14,       1, 32'hB0,      32'h14,       1, 5));
        v.push_back(mk(0, 0, 0, 0, 0,            0,      0,          0, 1, 32'hFF,      32'h14,       1, 32'hB0,      32'h14,       1, 5));
        v.push_back(mk(1, 1, 1, 1, 32'h40,       0,      0,          0, 0, 32'hFF,      32'h40,       1, 0,           0,            0, 5));
        v.push_back(mk(1, 0, 1, 0, 0,            0,      0,          0, 1, 32'hC0,      32'h44,       1, 0,           0,            0, 5));
        v.push_back(mk(1, 1, 0, 1, 32'h8000_0000, 0,     0,          0, 1, 32'hD0,      32'h8000_0000, 1, 32'hD0,     32'h48,       1, 6));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hD1,      32'h8000_0004, 1, 32'hD1,     32'h8000_0004, 1, 7));
        v.push_back(mk(1, 0, 0, 2, 0,            26'h10, 0,          0, 0, 0,           32'h8000_0040, 1, 32'hD1,     32'h8000_0004, 1, 7));
        v.push_back(mk(1, 1, 0, 3, 0,            0,      32'h1234,   0, 0, 0,           32'h1234,     1, 0,           0,            0, 7));
        v.push_back(mk(1, 1, 0, 1, 32'hFFFF_FFFC, 0,     0,          0, 0, 0,           32'hFFFF_FFFC, 1, 0,          0,            0, 7));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hE0,      32'h0,        1, 32'hE0,      32'h0,        1, 8));
        v.push_back(mk(1, 1, 0, 1, 32'h20,       0,      0,          0, 0, 0,           32'h20,       1, 0,           0,            0, 8));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          1, 1, 32'hF0,      32'h24,       0, 32'hF0,      32'h24,       1, 9));
        v.push_back(mk(1, 1, 0, 0, 0,            0,      0,          0, 1, 32'hF1,      32'h24,       0, 0,           0,            0, 9));
        v.push_back(mk(1, 1, 0, 1, 32'h80,       0,      0,          0, 1, 32'hF2,      32'h24,       0, 0,           0,            0, 9));

        #12;
        chk_all(-1, 32'h0, 1'b1, 0, 0, 1'b0, 0);
        nRST = 1'b1;
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(posedge CLK);
            #1;
            chk_all(i, v[i].e_addr, v[i].e_ren, v[i].e_ins, v[i].e_npc, v[i].e_vld, v[i].e_cnt);
        end

        // asynchronous reset while halted, no clock edge needed
        nRST = 1'b0;
        #2;
        chk_all(100, 32'h0, 1'b1, 0, 0, 1'b0, 0);
        nRST = 1'b1;
        pc_en = 1; id_en = 1; flushed = 0; pc_src = 0; halt = 0; ihit = 1; imemload = 32'h11;
        @(posedge CLK);
        #1;
        chk_all(101, 32'h4, 1'b1, 32'h11, 32'h4, 1'b1, 1);

        // stall, then asynchronous reset mid-stall
        pc_en = 0; id_en = 0; imemload = 32'h22;
        @(posedge CLK);
        #1;
        chk_all(102, 32'h4, 1'b1, 32'h11, 32'h4, 1'b1, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk_all(103, 32'h0, 1'b1, 0, 0, 1'b0, 0);
        nRST = 1'b1;

        // pc advances while IF/ID stalls
        pc_en = 1; id_en = 0; ihit = 1; imemload = 32'h33;
        @(posedge CLK);
        #1;
        chk_all(104, 32'h4, 1'b1, 0, 0, 1'b0, 0);
        id_en = 1;
        @(posedge CLK);
        #1;
        chk_all(105, 32'h8, 1'b1, 32'h33, 32'h8, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
